// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_encoder
//  Purpose  : Streaming RV32I field-bundle to instruction-word encoder with a
//             sequential word address. Encode register feeds a 2-entry skid
//             buffer. Optional immediate range checks: ENC_RANGE_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
    parameter int WORD_SIZE  = 32,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_class,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic                  in_alt,
    input  logic [WORD_SIZE-1:0]  in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_word,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  enc_error,
    output logic [7:0]            err_count
);

    localparam logic [3:0] c_cls_arith_reg = 4'd0;
    localparam logic [3:0] c_cls_arith_imm = 4'd1;
    localparam logic [3:0] c_cls_load      = 4'd2;
    localparam logic [3:0] c_cls_store     = 4'd3;
    localparam logic [3:0] c_cls_lui       = 4'd4;
    localparam logic [3:0] c_cls_auipc     = 4'd5;
    localparam logic [3:0] c_cls_branch    = 4'd6;
    localparam logic [3:0] c_cls_jal       = 4'd7;
    localparam logic [3:0] c_cls_jalr      = 4'd8;
    localparam logic [3:0] c_cls_ecall     = 4'd9;

    localparam logic [6:0] c_op_arith_reg = 7'b0110011;
    localparam logic [6:0] c_op_arith_imm = 7'b0010011;
    localparam logic [6:0] c_op_load      = 7'b0000011;
    localparam logic [6:0] c_op_store     = 7'b0100011;
    localparam logic [6:0] c_op_lui       = 7'b0110111;
    localparam logic [6:0] c_op_auipc     = 7'b0010111;
    localparam logic [6:0] c_op_branch    = 7'b1100011;
    localparam logic [6:0] c_op_jal       = 7'b1101111;
    localparam logic [6:0] c_op_jalr      = 7'b1100111;

    localparam logic [ADDR_WIDTH-1:0] c_base_addr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_addr_step = ADDR_WIDTH'(4);
    localparam logic [1:0]            c_buf_full  = 2'd2;

    logic [WORD_SIZE-1:0]  w_word;
    logic                  w_field_err;
    logic                  w_range_err;
    logic                  w_bad;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;

    logic                  r_enc_valid;
    logic [WORD_SIZE-1:0]  r_enc_word;
    logic [ADDR_WIDTH-1:0] r_enc_addr;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  r_err_pulse;
    logic [7:0]            r_err_count;
    logic [WORD_SIZE-1:0]  r_buf_word [2];
    logic [ADDR_WIDTH-1:0] r_buf_addr [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_cnt;

    always_comb begin
        w_word      = '0;
        w_field_err = 1'b0;
        case (in_class)
            c_cls_arith_reg:
                w_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, c_op_arith_reg};
            c_cls_arith_imm: begin
                // Shift-immediate forms carry funct7 in the upper immediate bits.
                if (in_funct3 == 3'b101)
                    w_word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, c_op_arith_imm};
                else if (in_funct3 == 3'b001)
                    w_word = {7'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, c_op_arith_imm};
                else
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_arith_imm};
            end
            c_cls_load: begin
                w_word      = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_load};
                w_field_err = (in_funct3 == 3'd3) || (in_funct3 == 3'd6) || (in_funct3 == 3'd7);
            end
            c_cls_store: begin
                w_word      = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], c_op_store};
                w_field_err = (in_funct3 > 3'd2);
            end
            c_cls_lui:
                w_word = {in_imm[31:12], in_rd, c_op_lui};
            c_cls_auipc:
                w_word = {in_imm[31:12], in_rd, c_op_auipc};
            c_cls_branch:
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], c_op_branch};
            c_cls_jal:
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, c_op_jal};
            c_cls_jalr:
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_jalr};
            c_cls_ecall:
                w_word = 32'h0000_0073;
            default:
                w_field_err = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic w_fits_i;
    logic w_fits_b;
    logic w_fits_j;
    logic w_is_shift;

    // A value fits a signed N-bit field when all bits from N-1 upward agree.
    assign w_fits_i   = (&in_imm[WORD_SIZE-1:11]) || !(|in_imm[WORD_SIZE-1:11]);
    assign w_fits_b   = (&in_imm[WORD_SIZE-1:12]) || !(|in_imm[WORD_SIZE-1:12]);
    assign w_fits_j   = (&in_imm[WORD_SIZE-1:20]) || !(|in_imm[WORD_SIZE-1:20]);
    assign w_is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    always_comb begin
        w_range_err = 1'b0;
        case (in_class)
            c_cls_arith_imm: w_range_err = w_is_shift ? (|in_imm[WORD_SIZE-1:5]) : !w_fits_i;
            c_cls_load,
            c_cls_store,
            c_cls_jalr:      w_range_err = !w_fits_i;
            c_cls_branch:    w_range_err = in_imm[0] || !w_fits_b;
            c_cls_jal:       w_range_err = in_imm[0] || !w_fits_j;
            c_cls_lui,
            c_cls_auipc:     w_range_err = |in_imm[11:0];
            default:         w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_bad     = w_field_err || w_range_err;
    assign in_ready  = !(r_enc_valid && (r_cnt == c_buf_full));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_enc_valid && ((r_cnt != c_buf_full) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_valid <= 1'b0;
            r_enc_word  <= '0;
            r_enc_addr  <= c_base_addr;
            r_next_addr <= c_base_addr;
            r_err_pulse <= 1'b0;
            r_err_count <= 8'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_word[i] <= '0;
                r_buf_addr[i] <= c_base_addr;
            end
        end else begin
            // The address is bound here so rejected bundles never consume one.
            if (w_accept && !w_bad) begin
                r_enc_valid <= 1'b1;
                r_enc_word  <= w_word;
                r_enc_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + c_addr_step;
            end else if (w_push) begin
                r_enc_valid <= 1'b0;
            end

            r_err_pulse <= w_accept && w_bad;
            if (w_accept && w_bad && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;

            if (w_push) begin
                r_buf_word[r_wr_ptr] <= r_enc_word;
                r_buf_addr[r_wr_ptr] <= r_enc_addr;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign out_word  = r_buf_word[r_rd_ptr];
    assign out_addr  = r_buf_addr[r_rd_ptr];
    assign enc_error = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_encoder
//  Purpose  : Directed scoreboard bench for instruction_encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [11:0] out_addr;
    logic        enc_error;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    instruction_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .enc_error (enc_error),
        .err_count (err_count)
    );

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          exp_errs  = 0;
    int          seen_errs = 0;
    logic [43:0] q [$];
    logic [11:0] model_addr = 12'd0;
    logic [31:0] pend_word  = 32'd0;
    logic        pend_err   = 1'b0;
    logic        accepted   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    // One clock: score the output, record acceptance, advance to edge + 1.
    task automatic step();
        logic [43:0] e;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_word", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q[0];
                check("out_word", out_word, e[31:0]);
                check("out_addr", {20'd0, out_addr}, {20'd0, e[43:32]});
                if (out_ready) void'(q.pop_front());
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            if (pend_err) exp_errs++;
            else begin
                q.push_back({model_addr, pend_word});
                model_addr += 12'd4;
            end
        end
        @(posedge clk);
        #1;
        if (enc_error) seen_errs++;
    endtask

    task automatic set_fields(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                              input logic [31:0] imm, input logic [31:0] exp_word, input logic exp_err);
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_alt    = alt;
        in_imm    = imm;
        pend_word = exp_word;
        pend_err  = exp_err;
        in_valid  = 1'b1;
    endtask

    task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm, input logic [31:0] exp_word, input logic exp_err);
        set_fields(cls, rd, rs1, rs2, f3, alt, imm, exp_word, exp_err);
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) step();
        if (!accepted) check("accept_timeout", {31'd0, accepted}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        check("drain_empty", q.size(), 32'd0);
        step();
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_pulses"}, seen_errs, exp_errs);
        check({tag, "_count"}, {24'd0, err_count}, (exp_errs > 255) ? 32'd255 : exp_errs);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_class  = 4'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_alt    = 1'b0;
        in_imm    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_addr", {20'd0, out_addr}, 32'd0);
        check("rst_enc_error", {31'd0, enc_error}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: word visible two cycles after presentation.
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h0050_0093, 1'b0);
        check("lat_stage1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_stage2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_word", out_word, 32'h0050_0093);
        check("lat_addr", {20'd0, out_addr}, 32'd0);
        drain();

        // Back-to-back ADD / SUB.
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h0020_81B3, 1'b0);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 32'h4020_81B3, 1'b0);
        check("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Format coverage, unused fields driven non-zero.
        send(4'd6, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(4'd7, 5'd0, 5'd7, 5'd7, 3'd0, 1'b0, 32'd8,        32'h0080_006F, 1'b0);
        send(4'd2, 5'd5, 5'd2, 5'd9, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFF1_2283, 1'b0);
        send(4'd3, 5'd7, 5'd1, 5'd3, 3'd2, 1'b0, 32'd8,        32'h0030_A423, 1'b0);
        send(4'd4, 5'd4, 5'd9, 5'd3, 3'd0, 1'b0, 32'h1234_5000, 32'h1234_5237, 1'b0);
        send(4'd5, 5'd1, 5'd9, 5'd3, 3'd0, 1'b0, 32'h0000_1000, 32'h0000_1097, 1'b0);
        send(4'd1, 5'd1, 5'd1, 5'd6, 3'd5, 1'b1, 32'd3,        32'h4030_D093, 1'b0);
        send(4'd1, 5'd1, 5'd1, 5'd6, 3'd1, 1'b1, 32'd2,        32'h0020_9093, 1'b0);
        send(4'd8, 5'd1, 5'd5, 5'd6, 3'd0, 1'b0, 32'd0,        32'h0002_80E7, 1'b0);
        send(4'd9, 5'd31, 5'd31, 5'd31, 3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0000_0073, 1'b0);
        drain();

        // Backpressure: sink stalled for 5 cycles while 4 bundles arrive.
        out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd11, addi(5'd1, 12'd11), 1'b0);
        send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd12, addi(5'd2, 12'd12), 1'b0);
        send(4'd1, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd13, addi(5'd3, 12'd13), 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        set_fields(4'd1, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd14, addi(5'd4, 12'd14), 1'b0);
        step();
        step();
        check("bp_held_off", {31'd0, accepted}, 32'd0);
        check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) step();
        check("bp_fourth_accepted", {31'd0, accepted}, 32'd1);
        in_valid = 1'b0;
        drain();

        // Rejected bundles; the following good word reuses the address.
        send(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        send(4'd3,  5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'd0, 32'd0, 1'b1);
        send(4'd2,  5'd1, 5'd1, 5'd0, 3'd6, 1'b0, 32'd0, 32'd0, 1'b1);
`ifdef ENC_RANGE_CHECK_EN
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096, 32'd0, 1'b1);
`else
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096, 32'h0000_0093, 1'b0);
`endif
        send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, addi(5'd2, 12'd7), 1'b0);
        drain();
        check_errs("err");

        // Saturation of the error counter.
        for (int i = 0; i < 256; i++)
            send(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        step();
        check_errs("sat");

        // Mid-stream reset discards buffered words.
        out_ready = 1'b0;
        send(4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, addi(5'd5, 12'd1), 1'b0);
        send(4'd1, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2, addi(5'd6, 12'd2), 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        check("mid_rst_out_addr", {20'd0, out_addr}, 32'd0);
        q.delete();
        model_addr = 12'd0;
        exp_errs   = 0;
        seen_errs  = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'd1, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, addi(5'd7, 12'd3), 1'b0);
        drain();

        // Address wrap past 2^ADDR_WIDTH-4 back to 0.
        for (int i = 0; i < 1024; i++)
            send(4'd1, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i % 2048),
                 addi(5'(i), 12'(i % 2048)), 1'b0);
        drain();
        check("wrap_model_addr", {20'd0, model_addr}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Streaming RV32I encoder: the inverse of the instruction decoder.
- Accepts decoded fields (class, registers, funct3, alt bit, 32-bit immediate) over a valid/ready handshake and packs them into 32-bit instruction words.
- Emits each word with a sequential word address for writing into instruction memory (bench program loader / self-test generator).
- Two-stage pipeline: encode register plus a 2-entry output skid buffer, giving full throughput under backpressure.

Parameters:
- WORD_SIZE, 32, instruction/immediate width
- BASE_ADDR, 0, byte address of first emitted word
- ADDR_WIDTH, 12, byte-address width; address wraps modulo 2^ADDR_WIDTH

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_class  in  4  0 ARITH_REG, 1 ARITH_IMM, 2 LOAD, 3 STORE, 4 LUI, 5 AUIPC, 6 BRANCH, 7 JAL, 8 JALR, 9 ECALL; 10-15 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3 / branch condition / load-store size
- in_alt  in  1  instruction bit 30 (SUB/SRA/SRAI)
- in_imm  in  WORD_SIZE  immediate, same meaning as the decoder immediate output
- out_valid  out  1  word valid
- out_ready  in  1  sink accepts word
- out_word  out  WORD_SIZE  encoded instruction
- out_addr  out  ADDR_WIDTH  byte address of out_word
- enc_error  out  1  one-cycle pulse: bundle rejected
- err_count  out  8  saturating count of rejected bundles

Behaviour:
- Reset (async assert, sync deassert use):
  - out_valid=0, out_word=0, out_addr=BASE_ADDR, enc_error=0, err_count=0.
  - Skid buffer emptied; next address counter set to BASE_ADDR.
  - Mid-operation reset discards all buffered words.
- Handshakes:
  - Input transfer when in_valid&&in_ready.
  - in_ready = !(encode stage full && skid buffer full); it is a registered function of occupancy only.
  - Output transfer when out_valid&&out_ready.
  - out_word/out_addr held stable while out_valid&&!out_ready.
- Latency: accepted bundle appears on out_word 2 cycles later when the sink is ready. Sustained 1 word/cycle. Words leave in acceptance order.
- Encoding: opcodes 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1100011, 1101111, 1100111, 1110011.
  - R: funct7={1'b0,in_alt,5'b0}.
  - I: imm[11:0] at bits 31:20. For ARITH_IMM funct3=101, bits 31:25={0,in_alt,00000} and bits 24:20=in_imm[4:0]. For ARITH_IMM funct3=001, bits 31:25=0.
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0]}.
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11]}.
  - U: imm[31:12].
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd}.
  - ECALL: fixed 0x00000073, fields ignored.
  - Fields unused by a format are forced 0: rd for S/B, rs2 for I/U/J, rs1 for U/J.
- Errors (evaluated in encode stage):
  - Illegal class.
  - STORE with funct3>2.
  - LOAD with funct3 in {3,6,7}.
  - Range violations (see Optional Feature).
  - On error: bundle consumed, no word emitted, address not advanced, enc_error pulses 1 cycle, err_count increments, saturating at 255.
- Address: increments by 4 per emitted word (at the encode stage, so buffered words keep their own address). Wraps to 0 after 2^ADDR_WIDTH-4 (not to BASE_ADDR).
- Simultaneous accept and emit with buffer full: allowed; occupancy unchanged, no bubble.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined:
  - I/S immediates must lie in [-2048,2047].
  - B immediates must be even and in [-4096,4094].
  - J immediates must be even and in [-2^20,2^20-2].
  - U immediates must have in_imm[11:0]==0.
  - Shift amounts must satisfy in_imm[31:5]==0.
  - Any violation raises the error path.
- Undefined: no range checks; immediates silently truncated to field bits. Class and funct3 checks remain.

Test Plan:
- Reset, then class1 rd=1 rs1=0 f3=0 imm=5 -> out_word 0x00500093, out_addr=0 after 2 cycles.
- Back-to-back: ADD x3,x1,x2 then SUB (alt=1) -> 0x002081B3 @0, 0x402081B3 @4, consecutive cycles.
- BRANCH f3=0 rs1=rs2=0 imm=-4 -> 0xFE000EE3; JAL rd=0 imm=8 -> 0x0080006F.
- out_ready=0 for 5 cycles while streaming 4 bundles -> in_ready drops after 3 accepted, no word lost or reordered, out_word stable while stalled.
- With ENC_RANGE_CHECK_EN: ADDI imm=4096 -> no word, enc_error pulse, err_count=1, next valid word reuses address. Without the macro -> 0x00000093.
- in_class=12 -> error. Assert rst_n low mid-stream -> out_valid=0 immediately, next word at BASE_ADDR.
